// File: rtl/cpu_pkg.sv
// Widths and controller state encoding shared by the program memory
// controller and the accumulator CPU core.
package cpu_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } state_t;

endpackage

// File: rtl/mem_array_16x8.sv
// Register-file memory: one write port, one registered read port.
// A synchronous reset clears every word and the read register.
module mem_array_16x8 #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // A read samples the array before this edge's write lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rdata <= '0;
    end else begin
      if (we) begin
        mem[waddr] <= wdata;
      end
      if (re) begin
        rdata <= mem[raddr];
      end
    end
  end

endmodule

// File: rtl/prog_mem_ctrl.sv
// Program/data memory controller: streams a boot image from the host,
// then serves fixed-latency CPU fetch/read/store requests.
module prog_mem_ctrl #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              run,
  output logic              load_err,
  output logic [ADDR_W:0]   load_cnt,
  output logic [DATA_W-1:0] load_sum,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ack
);

  import cpu_pkg::*;

  localparam int DEPTH_W = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH_W - 1);

  state_t state, next_state;

  logic [ADDR_W-1:0] wptr;
  logic              xfer;
  logic              cpu_req;
  logic              arr_we;
  logic [ADDR_W-1:0] arr_waddr;
  logic [DATA_W-1:0] arr_wdata;
  logic              arr_re;

  assign xfer    = ld_valid && ld_ready;
  assign cpu_req = mem_req && (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    ld_ready   = 1'b0;
    run        = 1'b0;
    load_err   = 1'b0;
    case (state)
      LOAD: begin
        ld_ready = 1'b1;
        if (xfer) begin
          if (ld_last) begin
            next_state = RUN;
          end else if (load_cnt == LAST_CNT) begin
            next_state = ERR;
          end
        end
      end
      RUN: begin
        run = 1'b1;
      end
      ERR: begin
        load_err = 1'b1;
      end
      default: begin
        next_state = LOAD;
      end
    endcase
  end

  // The loader and the CPU never own the write port in the same state.
  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = mem_addr;
    arr_wdata = mem_wdata;
    arr_re    = 1'b0;
    if (xfer) begin
      arr_we    = 1'b1;
      arr_waddr = wptr;
      arr_wdata = ld_data;
    end else if (cpu_req) begin
      arr_we = mem_we;
      arr_re = !mem_we;
    end
  end

  // wptr saturates at the last word since the 16th byte always leaves LOAD.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      load_cnt <= '0;
      load_sum <= '0;
    end else if (xfer) begin
      if (wptr != ADDR_W'(DEPTH_W - 1)) begin
        wptr <= wptr + ADDR_W'(1);
      end
      load_cnt <= load_cnt + (ADDR_W + 1)'(1);
      load_sum <= load_sum + ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_ack <= 1'b0;
    end else begin
      mem_ack <= cpu_req;
    end
  end

  mem_array_16x8 #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .re    (arr_re),
    .raddr (mem_addr),
    .rdata (mem_rdata)
  );

endmodule
